// File: rtl/cop_perf_responder.sv
// Coprocessor-side performance responder: CPU register reads/writes,
// seven gated event counters with sticky wrap flags, a counter-0 threshold
// flag, a freeze/resume/clear sequencer, and the active-low CONDINN output.
//
// state  | meaning
// RUN    | counting allowed (still gated by CTRL run/enable bits)
// FROZEN | counters hold their value, strobes ignored
// CLEAR  | zeroing counter k per cycle, k = 0..6, then back to saved state
module cop_perf_responder #(
  parameter int CNT_W   = 32,
  parameter bit RUN_RST = 1'b0
) (
  input  logic        SYSCLK,
  input  logic        RESET1N,
  input  logic [4:0]  CRDADDR,
  input  logic        CRDGEN,
  input  logic        CRDCON,
  input  logic        RHOLD,
  output logic [31:0] CRDDATA,
  input  logic [4:0]  CWRADDR,
  input  logic        CWRGEN,
  input  logic        CWRCON,
  input  logic [31:0] CWRDATA,
  input  logic        CNTINST,
  input  logic        CNTIMISS,
  input  logic        CNTISTALL,
  input  logic        CNTDMISS,
  input  logic        CNTDSTALL,
  input  logic        CNTDLOAD,
  input  logic        CNTDSTORE,
  output logic        CONDINN
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FROZEN = 2'd1,
    ST_CLEAR  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  state_t           ret_state, ret_nxt;
  logic [2:0]       clr_k, k_nxt;
  logic [CNT_W-1:0] cnt [7];
  logic [9:0]       ctrl;
  logic [7:0]       ovf;
  logic [31:0]      thresh;

  logic [6:0]       strb;
  logic             wr_ctrl, wr_ovf, wr_cmd, wr_thr;
  logic             cmd_clr, cmd_frz, cmd_res;
  state_t           base_st, applied_st;
  logic             clearing, count_ok;
  logic [2:0]       clr_idx;
  logic [6:0]       inc, wr_cnt, clr_hit, wrap;
  logic             thr_hit;
  logic [CNT_W-1:0] cnt0_plus;
  logic [31:0]      cnt0_plus_ext;
  logic [31:0]      rd_gen_val, rd_con_val;

  assign strb = {CNTDSTORE, CNTDLOAD, CNTDSTALL, CNTDMISS, CNTISTALL, CNTIMISS, CNTINST};

  // Control-register write decode
  always_comb begin
    wr_ctrl = CWRCON && (CWRADDR == 5'd0);
    wr_ovf  = CWRCON && (CWRADDR == 5'd1);
    wr_cmd  = CWRCON && (CWRADDR == 5'd2);
    wr_thr  = CWRCON && (CWRADDR == 5'd3);
    cmd_clr = wr_cmd && CWRDATA[0];
    cmd_frz = wr_cmd && CWRDATA[1];
    cmd_res = wr_cmd && CWRDATA[2];
  end

  // FSM state register with saved return state and clear index
  always_ff @(posedge SYSCLK or negedge RESET1N) begin
    if (!RESET1N) begin
      state     <= ST_RUN;
      ret_state <= ST_RUN;
      clr_k     <= 3'd0;
    end else begin
      state     <= state_nxt;
      ret_state <= ret_nxt;
      clr_k     <= k_nxt;
    end
  end

  // FSM next state; freeze beats resume, and in CLEAR they only retarget the exit
  always_comb begin
    base_st    = (state == ST_CLEAR) ? ret_state : state;
    applied_st = cmd_frz ? ST_FROZEN : (cmd_res ? ST_RUN : base_st);
    state_nxt  = state;
    ret_nxt    = ret_state;
    k_nxt      = clr_k;
    if (cmd_clr) begin
      state_nxt = ST_CLEAR;
      ret_nxt   = applied_st;
      // a re-issued clear acts as the k=0 cycle itself
      k_nxt     = (state == ST_CLEAR) ? 3'd1 : 3'd0;
    end else if (state == ST_CLEAR) begin
      ret_nxt = applied_st;
      if (clr_k == 3'd6) state_nxt = applied_st;
      else               k_nxt     = clr_k + 3'd1;
    end else begin
      state_nxt = applied_st;
    end
  end

  // FSM outputs: per-counter increment, write, clear and wrap qualifiers
  always_comb begin
    clearing      = (state == ST_CLEAR);
    clr_idx       = (clearing && cmd_clr) ? 3'd0 : clr_k;
    count_ok      = (state == ST_RUN) && ctrl[8];
    inc           = '0;
    wr_cnt        = '0;
    clr_hit       = '0;
    wrap          = '0;
    for (int i = 0; i < 7; i++) begin
      inc[i]     = count_ok && ctrl[i] && strb[i];
      wr_cnt[i]  = CWRGEN && (CWRADDR == 5'(i)) && !clearing;
      clr_hit[i] = clearing && (clr_idx == 3'(i));
      wrap[i]    = inc[i] && !wr_cnt[i] && (cnt[i] == '1);
    end
    cnt0_plus                   = cnt[0] + CNT_W'(1);
    cnt0_plus_ext               = '0;
    cnt0_plus_ext[CNT_W-1:0]    = cnt0_plus;
    thr_hit = inc[0] && !wr_cnt[0] && (thresh != 32'd0) && (cnt0_plus_ext == thresh);
  end

  // Event counters: clear sweep, then CPU write, then increment
  always_ff @(posedge SYSCLK or negedge RESET1N) begin
    if (!RESET1N) begin
      for (int i = 0; i < 7; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 7; i++) begin
        if (clr_hit[i])     cnt[i] <= '0;
        else if (wr_cnt[i]) cnt[i] <= CWRDATA[CNT_W-1:0];
        else if (inc[i])    cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end

  // Control, threshold and sticky overflow registers; a new set beats W1C
  always_ff @(posedge SYSCLK or negedge RESET1N) begin
    if (!RESET1N) begin
      ctrl   <= {1'b0, RUN_RST, 8'h00};
      ovf    <= 8'h00;
      thresh <= 32'd0;
    end else begin
      if (wr_ctrl) ctrl <= {CWRDATA[9:8], 1'b0, CWRDATA[6:0]};
      if (wr_thr)  thresh <= CWRDATA;
      if (wr_ovf)  ovf <= (ovf & ~CWRDATA[7:0]) | {thr_hit, wrap};
      else         ovf <= ovf | {thr_hit, wrap};
    end
  end

  // Read multiplexers, zero-extending counters to 32 bits
  always_comb begin
    rd_gen_val = '0;
    for (int i = 0; i < 7; i++) begin
      if (CRDADDR == 5'(i)) rd_gen_val[CNT_W-1:0] = cnt[i];
    end
    case (CRDADDR)
      5'd0:    rd_con_val = {22'd0, ctrl};
      5'd1:    rd_con_val = {24'd0, ovf};
      5'd2:    rd_con_val = {30'd0, state};
      5'd3:    rd_con_val = thresh;
      default: rd_con_val = 32'd0;
    endcase
  end

  // Registered read data; hold wins, control space wins over general
  always_ff @(posedge SYSCLK or negedge RESET1N) begin
    if (!RESET1N)                         CRDDATA <= 32'd0;
    else if (!RHOLD && (CRDGEN || CRDCON)) CRDDATA <= CRDCON ? rd_con_val : rd_gen_val;
  end

  // Registered active-low condition back to the CPU
  always_ff @(posedge SYSCLK or negedge RESET1N) begin
    if (!RESET1N) CONDINN <= 1'b1;
    else          CONDINN <= ~(ctrl[9] & (|ovf));
  end

endmodule
